// File: rtl/dcache_pkg.sv
// Shared types and helpers for the MEM-stage data cache controller.
// Address layout: byte offset [1:0], set index above it, tag in the remaining upper bits.
package dcache_pkg;

    localparam int DEFAULT_NUM_SET = 8;

    typedef enum logic [2:0] {
        ST_FLUSH,
        ST_IDLE,
        ST_RD_REQ,
        ST_RD_WAIT,
        ST_WR_REQ,
        ST_DONE
    } dc_state_e;

    // Set index of a byte address, right-aligned in a 30-bit field.
    function automatic logic [29:0] set_of(input logic [31:0] addr, input int set_w);
        set_of = addr[31:2] & ((30'd1 << set_w) - 30'd1);
    endfunction

    // Tag of a byte address, right-aligned in a 30-bit field.
    function automatic logic [29:0] tag_of(input logic [31:0] addr, input int set_w);
        tag_of = addr[31:2] >> set_w;
    endfunction

endpackage

// File: rtl/dcache_perf_counters.sv
// Saturating hit/miss counters for the data cache; they stick at all-ones instead of wrapping.
module dcache_perf_counters #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_hit,
    input  logic             inc_miss,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count
);

    logic [CNT_W-1:0] hit_q, hit_d;
    logic [CNT_W-1:0] miss_q, miss_d;

    always_comb begin
        hit_d  = hit_q;
        miss_d = miss_q;
        if (inc_hit && (hit_q != '1)) begin
            hit_d = hit_q + CNT_W'(1);
        end
        if (inc_miss && (miss_q != '1)) begin
            miss_d = miss_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_q  <= '0;
            miss_q <= '0;
        end else begin
            hit_q  <= hit_d;
            miss_q <= miss_d;
        end
    end

    assign hit_count  = hit_q;
    assign miss_count = miss_q;

endmodule

// File: rtl/dcache_controller.sv
// Sequencer for the direct-mapped, one-word-per-line MEM-stage data cache:
// hit/miss loads, write-through no-allocate stores, invalidate sweep and perf counters.
module dcache_controller
    import dcache_pkg::*;
#(
    parameter int NUM_SET = DEFAULT_NUM_SET,
    parameter int CNT_W   = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       MemReadM,
    input  logic                       MemWriteM,
    input  logic [31:0]                ALUResultM,
    input  logic [31:0]                WriteDataM,
    input  logic                       flush_i,
    input  logic                       Hit,
    input  logic [31:0]                cache_rdata_i,
    output logic                       StallM,
    output logic [31:0]                ReadDataM,
    output logic                       cache_fill_en,
    output logic [31:0]                cache_fill_data,
    output logic                       cache_inv_en,
    output logic [$clog2(NUM_SET)-1:0] cache_inv_set,
    output logic                       mem_req_valid,
    input  logic                       mem_req_ready,
    output logic                       mem_we,
    output logic [31:0]                mem_addr,
    output logic [31:0]                mem_wdata,
    input  logic                       mem_rvalid,
    input  logic [31:0]                mem_rdata,
    output logic [CNT_W-1:0]           hit_count,
    output logic [CNT_W-1:0]           miss_count
);

    localparam int SET_W = $clog2(NUM_SET);
    localparam logic [SET_W-1:0] LAST_SET = SET_W'(NUM_SET - 1);

    dc_state_e         state_q, state_d;
    logic [SET_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              we_q, we_d;
    logic              inc_hit, inc_miss;

    // Memory handshake: a request transfers on a posedge where mem_req_valid and
    // mem_req_ready are both high; until then mem_we/mem_addr/mem_wdata come from
    // registers latched in IDLE and cannot change. mem_rvalid is a one-cycle response.
    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        rdata_d         = rdata_q;
        addr_d          = addr_q;
        wdata_d         = wdata_q;
        we_d            = we_q;
        StallM          = 1'b1;
        ReadDataM       = 32'h0;
        cache_fill_en   = 1'b0;
        cache_fill_data = 32'h0;
        cache_inv_en    = 1'b0;
        cache_inv_set   = '0;
        mem_req_valid   = 1'b0;
        inc_hit         = 1'b0;
        inc_miss        = 1'b0;

        case (state_q)
            ST_FLUSH: begin
                cache_inv_en  = 1'b1;
                cache_inv_set = cnt_q;
                if (cnt_q == LAST_SET) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + SET_W'(1);
                end
            end
            ST_IDLE: begin
                StallM = 1'b0;
                if (flush_i) begin
                    // A request seen alongside the flush stays frozen until the sweep ends.
                    StallM  = MemReadM | MemWriteM;
                    state_d = ST_FLUSH;
                    cnt_d   = '0;
                end else if (MemWriteM) begin
                    StallM  = 1'b1;
                    state_d = ST_WR_REQ;
                    we_d    = 1'b1;
                    addr_d  = ALUResultM & 32'hFFFF_FFFC;
                    wdata_d = WriteDataM;
                    if (Hit) begin
                        cache_fill_en   = 1'b1;
                        cache_fill_data = WriteDataM;
                    end
                end else if (MemReadM) begin
                    if (Hit) begin
                        ReadDataM = cache_rdata_i;
                        inc_hit   = 1'b1;
                    end else begin
                        StallM   = 1'b1;
                        inc_miss = 1'b1;
                        state_d  = ST_RD_REQ;
                        we_d     = 1'b0;
                        addr_d   = ALUResultM & 32'hFFFF_FFFC;
                        wdata_d  = WriteDataM;
                    end
                end
            end
            ST_RD_REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) begin
                    state_d = ST_RD_WAIT;
                end
            end
            ST_WR_REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) begin
                    state_d = ST_DONE;
                end
            end
            ST_RD_WAIT: begin
                if (mem_rvalid) begin
                    cache_fill_en   = 1'b1;
                    cache_fill_data = mem_rdata;
                    rdata_d         = mem_rdata;
                    state_d         = ST_DONE;
                end
            end
            ST_DONE: begin
                StallM    = 1'b0;
                ReadDataM = we_q ? 32'h0 : rdata_q;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_FLUSH;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_FLUSH;
            cnt_q   <= '0;
            rdata_q <= 32'h0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
        end
    end

    assign mem_we    = (state_q == ST_WR_REQ);
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    dcache_perf_counters #(
        .CNT_W(CNT_W)
    ) u_perf (
        .clk       (clk),
        .rst       (rst),
        .inc_hit   (inc_hit),
        .inc_miss  (inc_miss),
        .hit_count (hit_count),
        .miss_count(miss_count)
    );

endmodule
